// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, fetch handshake, branch/jump redirect.
// Optional misaligned-target trapping is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_INC   = 4,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    input  logic             pc_ready,
    input  logic             br_en,
    input  logic [2:0]       br_funct3,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             jal,
    input  logic             jalr,
    input  logic [XLEN-1:0]  pc_ex,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  link_pc,
    output logic             flush,
    output logic             trap,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_TRAP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             cond;
    logic             taken;
    logic             run;
    logic             fire;
    logic             misalign;
    logic [XLEN-1:0]  target_raw;
    logic [XLEN-1:0]  target;

    always_comb begin
        cond = 1'b0;
        unique case (br_funct3)
            3'b000:  cond = zero;
            3'b001:  cond = !zero;
            3'b100:  cond = lt;
            3'b101:  cond = !lt;
            3'b110:  cond = ltu;
            3'b111:  cond = !ltu;
            default: cond = 1'b0;
        endcase
    end

    assign run   = (state_q == S_RUN);
    assign taken = jal | jalr | (br_en & cond);
    assign fire  = run & pc_ready;

    // JALR clears bit 0 of its sum; jalr has priority over jal.
    assign target_raw = jalr ? ((rs1 + imm) & ~XLEN'(1))
                             : (pc_ex + imm);

`ifdef PC_MISALIGN_TRAP_EN
    logic trap_q, trap_d;

    assign misalign = target_raw[1];
    assign target   = target_raw;
    assign trap     = trap_q;
`else
    assign misalign = 1'b0;
    assign target   = target_raw & ~XLEN'(3);
    assign trap     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q + CNT_W'(fire);
`ifdef PC_MISALIGN_TRAP_EN
        trap_d  = trap_q;
`endif
        unique case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (taken) begin
                    if (misalign) begin
                        state_d = S_TRAP;
`ifdef PC_MISALIGN_TRAP_EN
                        trap_d  = 1'b1;
`endif
                    end else begin
                        pc_d = target;
                    end
                end else if (fire) begin
                    pc_d = pc_q + XLEN'(PC_INC);
                end
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q  <= trap_d;
`endif
        end
    end

    assign pc        = pc_q;
    assign pc_valid  = run;
    assign flush     = taken & run;
    assign link_pc   = pc_ex + XLEN'(PC_INC);
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic
// checked against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        br_en;
    logic [2:0]  br_funct3;
    logic        zero, lt, ltu, jal, jalr;
    logic [31:0] pc_ex, rs1, imm;
    logic [31:0] link_pc;
    logic        flush, trap;
    logic [15:0] fetch_cnt;

    logic        w_rst_n = 1'b0;
    logic        w_one = 1'b1;
    logic        w_zb = 1'b0;
    logic [2:0]  w_f3 = 3'b010;
    logic [31:0] w_zw = 32'h0;
    logic [31:0] w_pc, w_link;
    logic        w_valid, w_flush, w_trap;
    logic [3:0]  w_cnt;

    pc_sequencer #(.XLEN(32), .RESET_PC(RPC), .PC_INC(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid),
        .pc_ready(pc_ready), .br_en(br_en), .br_funct3(br_funct3),
        .zero(zero), .lt(lt), .ltu(ltu), .jal(jal), .jalr(jalr),
        .pc_ex(pc_ex), .rs1(rs1), .imm(imm), .link_pc(link_pc),
        .flush(flush), .trap(trap), .fetch_cnt(fetch_cnt)
    );

    pc_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFF0), .PC_INC(4), .CNT_W(4)) u_w (
        .clk(clk), .rst_n(w_rst_n), .pc(w_pc), .pc_valid(w_valid),
        .pc_ready(w_one), .br_en(w_zb), .br_funct3(w_f3),
        .zero(w_zb), .lt(w_zb), .ltu(w_zb), .jal(w_zb), .jalr(w_zb),
        .pc_ex(w_zw), .rs1(w_zw), .imm(w_zw), .link_pc(w_link),
        .flush(w_flush), .trap(w_trap), .fetch_cnt(w_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: phase 0 = booting, 1 = running, 2 = trapped
    bit          m_known = 0;
    int          m_ph = 0;
    logic [31:0] m_pc = 32'h0;
    logic [15:0] m_cnt = 16'h0;
    bit          m_trap = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit br_cond(logic [2:0] f3, bit z, bit l, bit lu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            3'd7: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic cyc(input bit rst, input bit rdy, input bit be,
                       input logic [2:0] f3, input bit z, input bit l,
                       input bit lu, input bit j, input bit jr,
                       input logic [31:0] pe, input logic [31:0] r1,
                       input logic [31:0] im);
        bit          tk;
        bit          fire;
        logic [31:0] tgt;
        @(negedge clk);
        rst_n = rst; pc_ready = rdy; br_en = be; br_funct3 = f3;
        zero = z; lt = l; ltu = lu; jal = j; jalr = jr;
        pc_ex = pe; rs1 = r1; imm = im;
        #1;
        tk   = j || jr || (be && br_cond(f3, z, l, lu));
        tgt  = jr ? ((r1 + im) & ~32'h1) : (pe + im);
        fire = (m_ph == 1) && rdy;
        chk("link_pc", link_pc, pe + 32'd4);
        if (m_known) begin
            chk("pc", pc, m_pc);
            chk("pc_valid", pc_valid, m_ph == 1);
            chk("flush", flush, tk && m_ph == 1);
            chk("trap", trap, m_trap);
            chk("fetch_cnt", fetch_cnt, m_cnt);
        end
        @(posedge clk);
        if (!rst) begin
            m_known = 1; m_ph = 0; m_pc = RPC; m_cnt = 0; m_trap = 0;
        end else if (m_known) begin
            if (fire) m_cnt = m_cnt + 16'd1;
            if (m_ph == 0) begin
                m_ph = 1;
            end else if (m_ph == 1) begin
                if (tk) begin
`ifdef PC_MISALIGN_TRAP_EN
                    if (tgt[1]) begin
                        m_ph = 2; m_trap = 1;
                    end else begin
                        m_pc = tgt;
                    end
`else
                    m_pc = tgt & ~32'h3;
`endif
                end else if (fire) begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic idle(input bit rdy);
        cyc(1, rdy, 0, 3'd2, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] ri;
        cyc(0, 0, 0, 3'd2, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("rst_pc", pc, RPC);
        chk("rst_valid", pc_valid, 1'b0);
        chk("rst_cnt", fetch_cnt, 16'd0);
        chk("rst_trap", trap, 1'b0);

        repeat (4) idle(1);
        #1;
        chk("seq_cnt3", fetch_cnt, 16'd3);
        chk("seq_pc", pc, 32'h10C);

        repeat (3) idle(0);
        #1;
        chk("stall_pc", pc, 32'h10C);
        chk("stall_cnt", fetch_cnt, 16'd3);
        chk("stall_valid", pc_valid, 1'b1);

        cyc(1, 1, 1, 3'b001, 0, 0, 0, 0, 0, 32'h200, 32'h0, 32'hFFFF_FFF8);
        #1;
        chk("bne_pc", pc, 32'h1F8);
        chk("bne_cnt", fetch_cnt, 16'd4);

        cyc(1, 1, 1, 3'b111, 0, 0, 1, 0, 0, 32'h200, 32'h0, 32'h40);
        #1;
        chk("bgeu_pc", pc, 32'h1FC);

        cyc(1, 0, 0, 3'd0, 0, 0, 0, 0, 1, 32'h300, 32'h1003, 32'h4);
        #1;
        chk("jalr_link", link_pc, 32'h304);
`ifdef PC_MISALIGN_TRAP_EN
        chk("jalr_pc", pc, 32'h1FC);
        chk("jalr_trap", trap, 1'b1);
        chk("jalr_valid", pc_valid, 1'b0);
`else
        chk("jalr_pc", pc, 32'h1004);
        chk("jalr_trap", trap, 1'b0);
`endif

        cyc(0, 1, 0, 3'd0, 0, 0, 0, 1, 0, 32'h400, 32'h0, 32'h40);
        #1;
        chk("rstjal_pc", pc, RPC);
        chk("rstjal_flush", flush, 1'b0);

        idle(0);
        cyc(1, 0, 0, 3'd0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        #1;
        chk("jal_hi_pc", pc, 32'hFFFF_FFFC);
        idle(1);
        #1;
        chk("wrap_pc", pc, 32'h0);

        for (int i = 0; i < 400; i++) begin
            ri = $urandom_range(0, 1) ? $urandom
                                      : (($urandom_range(0, 255) << 2) - 32'd512);
            cyc($urandom_range(0, 39) != 0, $urandom_range(0, 1),
                $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom & ~32'h3, $urandom, ri);
        end

        #1;
        w_rst_n = 1'b1;
        repeat (5) idle(1);
        #1;
        chk("w_pc_wrap", w_pc, 32'h0);
        chk("w_cnt4", w_cnt, 4'd4);
        chk("w_valid", w_valid, 1'b1);
        repeat (12) idle(1);
        #1;
        chk("w_cnt_wrap", w_cnt, 4'd0);
        chk("w_pc_end", w_pc, 32'h30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
